// File: rtl/cam_tx_pkg.sv
// Shared types and helpers for the DVP test-pattern transmitter:
// frame FSM states, pattern codes, colour-bar table and RGB444 byte packing.
package cam_tx_pkg;

    localparam int unsigned CoordW = 12;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } state_e;

    typedef enum logic [1:0] {
        PatBars    = 2'd0,
        PatRamp    = 2'd1,
        PatChecker = 2'd2,
        PatSolid   = 2'd3
    } pattern_e;

    function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
        logic [11:0] rgb;
        case (idx)
            3'd0:    rgb = 12'hFFF;
            3'd1:    rgb = 12'hFF0;
            3'd2:    rgb = 12'h0FF;
            3'd3:    rgb = 12'h0F0;
            3'd4:    rgb = 12'hF0F;
            3'd5:    rgb = 12'hF00;
            3'd6:    rgb = 12'h00F;
            default: rgb = 12'h000;
        endcase
        return rgb;
    endfunction

    // Even byte carries R in the low nibble, odd byte carries {G,B}.
    function automatic logic [7:0] pack_rgb444(input logic [11:0] rgb, input logic odd);
        return odd ? rgb[7:0] : {4'h0, rgb[11:8]};
    endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern source: maps pixel coordinates and the latched
// pattern selection to a 12-bit RGB444 colour.
module cam_pattern_gen
    import cam_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic [CoordW-1:0] x,
    input  logic [CoordW-1:0] y,
    input  pattern_e          sel,
    input  logic [11:0]       solid,
    output logic [11:0]       rgb
);

    localparam int unsigned BarW = H_ACTIVE / 8;

    logic [3:0] ramp;
    logic       check_on;

    assign ramp     = 4'((32'(x) << 4) / H_ACTIVE);
    assign check_on = |(((x ^ y) >> CHECK_LOG2) & CoordW'(1));

    always_comb begin
        rgb = 12'h000;
        case (sel)
            PatBars:    rgb = bar_rgb(3'(32'(x) / BarW));
            PatRamp:    rgb = {ramp, ramp, ramp};
            PatChecker: rgb = check_on ? 12'hFFF : 12'h000;
            PatSolid:   rgb = solid;
            default:    rgb = 12'h000;
        endcase
    end

endmodule

// File: rtl/cam_dvp_pattern_tx.sv
// Camera-side DVP transmitter: frame/line timing FSM producing vsync/href and
// RGB444 byte data from internal test patterns, one byte per clock.
module cam_dvp_pattern_tx
    import cam_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned H_BLANK    = 144,
    parameter int unsigned V_SYNC     = 3,
    parameter int unsigned V_BACK     = 17,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_rgb,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int unsigned LINE_T      = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned FRAME_LINES = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned HCNT_W      = $clog2(LINE_T);
    localparam int unsigned VCNT_W      = $clog2(FRAME_LINES);

    localparam logic [HCNT_W-1:0] HcntLast   = HCNT_W'(LINE_T - 1);
    localparam logic [HCNT_W-1:0] HrefEnd    = HCNT_W'(2 * H_ACTIVE);
    localparam logic [VCNT_W-1:0] VfrontLast = VCNT_W'(V_FRONT - 1);

    state_e            state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic [VCNT_W-1:0] vcnt_last;
    pattern_e          sel_q;
    logic [11:0]       solid_q;
    logic              href_d, start_d, done_d;
    logic [11:0]       pix_rgb;

    always_comb begin
        case (state_q)
            StVsync:  vcnt_last = VCNT_W'(V_SYNC - 1);
            StVback:  vcnt_last = VCNT_W'(V_BACK - 1);
            StActive: vcnt_last = VCNT_W'(V_ACTIVE - 1);
            StVfront: vcnt_last = VfrontLast;
            default:  vcnt_last = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        if (state_q == StIdle) begin
            hcnt_d = '0;
            vcnt_d = '0;
            if (enable) state_d = StVsync;
        end else if (hcnt_q != HcntLast) begin
            hcnt_d = hcnt_q + HCNT_W'(1);
        end else begin
            hcnt_d = '0;
            if (vcnt_q != vcnt_last) begin
                vcnt_d = vcnt_q + VCNT_W'(1);
            end else begin
                vcnt_d = '0;
                unique case (state_q)
                    StVsync:  state_d = StVback;
                    StVback:  state_d = StActive;
                    StActive: state_d = StVfront;
                    StVfront: state_d = enable ? StVsync : StIdle;
                    default:  state_d = StIdle;
                endcase
            end
        end
    end

    // Outputs are derived from next-state values so they land on the same edge as the state.
    assign href_d  = (state_d == StActive) && (hcnt_d < HrefEnd);
    assign start_d = (state_d == StVsync) && (vcnt_d == '0) && (hcnt_d == '0);
    assign done_d  = (state_d == StVfront) && (vcnt_d == VfrontLast) && (hcnt_d == HcntLast);

    cam_pattern_gen #(
        .H_ACTIVE   (H_ACTIVE),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_pattern_gen (
        .x     (CoordW'(hcnt_d >> 1)),
        .y     (CoordW'(vcnt_d)),
        .sel   (sel_q),
        .solid (solid_q),
        .rgb   (pix_rgb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            sel_q       <= PatBars;
            solid_q     <= '0;
            cam_vsync   <= 1'b0;
            cam_href    <= 1'b0;
            cam_data    <= 8'h00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            cam_vsync   <= (state_d == StVsync);
            cam_href    <= href_d;
            cam_data    <= href_d ? pack_rgb444(pix_rgb, hcnt_d[0]) : 8'h00;
            frame_start <= start_d;
            frame_done  <= done_d;
            if (done_d) frame_count <= frame_count + 16'd1;
            if (start_d) begin
                sel_q   <= pattern_e'(pattern_sel);
                solid_q <= solid_rgb;
            end
        end
    end

endmodule

// File: tb/tb_cam_dvp_pattern_tx.sv
// Self-checking bench for cam_dvp_pattern_tx using a small frame geometry and a
// frame-offset based reference model of the expected DVP waveform.
module tb_cam_dvp_pattern_tx;

    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HB = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int CL = 1;
    localparam int LT = 2 * HA + HB;
    localparam int FT = (VS + VB + VA + VF) * LT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [11:0] solid_rgb = 12'h000;
    logic        cam_vsync, cam_href, frame_start, frame_done;
    logic [7:0]  cam_data;
    logic [15:0] frame_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_count = 16'h0000;
    logic [1:0]  cur_sel = 2'd0;
    logic [11:0] cur_rgb = 12'h000;

    logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    logic [7:0]  bars_line [16] = '{8'h0F, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hF0,
                                    8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00};

    cam_dvp_pattern_tx #(
        .H_ACTIVE   (HA),
        .V_ACTIVE   (VA),
        .H_BLANK    (HB),
        .V_SYNC     (VS),
        .V_BACK     (VB),
        .V_FRONT    (VF),
        .CHECK_LOG2 (CL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_rgb(int x, int y, logic [1:0] sel, logic [11:0] rgb);
        logic [3:0] g;
        case (sel)
            2'd0: return bar_tab[(x * 8) / HA];
            2'd1: begin
                g = 4'((x * 16) / HA);
                return {g, g, g};
            end
            2'd2: return ((((x ^ y) >> CL) & 1) != 0) ? 12'hFFF : 12'h000;
            default: return rgb;
        endcase
    endfunction

    // Expected {vsync, href, data, frame_start, frame_done} at clock t of a frame.
    function automatic logic [11:0] model_out(int t, logic [1:0] sel, logic [11:0] rgb);
        int          line, h;
        logic        vs, hr;
        logic [11:0] c;
        logic [7:0]  d;
        line = t / LT;
        h    = t % LT;
        vs   = (line < VS);
        hr   = (line >= VS + VB) && (line < VS + VB + VA) && (h < 2 * HA);
        c    = model_rgb(h / 2, line - VS - VB, sel, rgb);
        d    = hr ? (((h % 2) == 0) ? {4'h0, c[11:8]} : c[7:0]) : 8'h00;
        return {vs, hr, d, (t == 0), (t == FT - 1)};
    endfunction

    task automatic wait_start(input string name, output int waited);
        waited = 0;
        while (frame_start !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL %s_start: frame_start=%b after %0d clks, required 1",
                     name, frame_start, waited);
        end
    endtask

    task automatic check_frame(input string name, input logic [1:0] sel, input logic [11:0] rgb,
                               input int mid_t, input logic [1:0] mid_sel,
                               input logic [11:0] mid_rgb, input logic [1:0] nxt_sel,
                               input logic [11:0] nxt_rgb, input int drop_t);
        int          w;
        logic [11:0] exp_o, got_o;
        logic [15:0] exp_c;
        wait_start(name, w);
        for (int t = 0; t < FT; t++) begin
            exp_o = model_out(t, sel, rgb);
            got_o = {cam_vsync, cam_href, cam_data, frame_start, frame_done};
            exp_c = (t == FT - 1) ? exp_count + 16'd1 : exp_count;
            n_cmp++;
            if (got_o !== exp_o) begin
                n_err++;
                $display("FAIL %s t=%0d: {vs,href,data,fs,fd}=%b, required %b",
                         name, t, got_o, exp_o);
            end
            n_cmp++;
            if (frame_count !== exp_c) begin
                n_err++;
                $display("FAIL %s_count t=%0d: frame_count=%h, required %h",
                         name, t, frame_count, exp_c);
            end
            if (t == mid_t) begin
                pattern_sel = mid_sel;
                solid_rgb   = mid_rgb;
            end
            if (t == FT - 15) begin
                pattern_sel = nxt_sel;
                solid_rgb   = nxt_rgb;
            end
            if (t == drop_t) enable = 1'b0;
            @(negedge clk);
        end
        exp_count = exp_count + 16'd1;
        cur_sel   = nxt_sel;
        cur_rgb   = nxt_rgb;
    endtask

    task automatic check_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            n_cmp++;
            if ({cam_vsync, cam_href, cam_data, frame_start, frame_done} !== 12'h000 ||
                frame_count !== exp_count) begin
                n_err++;
                $display("FAIL %s i=%0d: {vs,href,data,fs,fd}=%b count=%h, required 0 count=%h",
                         name, i, {cam_vsync, cam_href, cam_data, frame_start, frame_done},
                         frame_count, exp_count);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset", 1);
        reset = 1'b0;
        check_quiet("idle", 50);
    endtask

    task automatic test_frame_timing();
        pattern_sel = 2'd0;
        solid_rgb   = 12'h000;
        cur_sel     = 2'd0;
        cur_rgb     = 12'h000;
        enable      = 1'b1;
        check_frame("timing", 2'd0, 12'h000, -1, 2'd0, 12'h000, 2'd0, 12'h000, -1);
        n_cmp++;
        if (frame_start !== 1'b1 || cam_vsync !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_back: fs=%b vs=%b, required 1 1", frame_start, cam_vsync);
        end
    endtask

    task automatic test_colour_bars();
        int         w;
        logic [8:0] exp_b;
        wait_start("bars", w);
        for (int t = 0; t < FT; t++) begin
            if (t >= 2 * LT && t < 3 * LT) begin
                exp_b = (t - 2 * LT < 2 * HA) ? {1'b1, bars_line[t - 2 * LT]} : 9'h000;
                n_cmp++;
                if ({cam_href, cam_data} !== exp_b) begin
                    n_err++;
                    $display("FAIL bars_line t=%0d: {href,data}=%h, required %h",
                             t, {cam_href, cam_data}, exp_b);
                end
            end
            if (t == FT - 1) begin
                n_cmp++;
                if (frame_done !== 1'b1 || frame_count !== exp_count + 16'd1) begin
                    n_err++;
                    $display("FAIL bars_done: fd=%b count=%h, required 1 %h",
                             frame_done, frame_count, exp_count + 16'd1);
                end
            end
            if (t == FT - 15) begin
                pattern_sel = 2'd3;
                solid_rgb   = 12'hA5C;
            end
            @(negedge clk);
        end
        exp_count = exp_count + 16'd1;
        cur_sel   = 2'd3;
        cur_rgb   = 12'hA5C;
    endtask

    task automatic test_solid_latch();
        check_frame("solid", cur_sel, cur_rgb, 30, 2'd0, 12'h123, 2'd0, 12'h123, -1);
        check_frame("bars_next", cur_sel, cur_rgb, -1, 2'd0, 12'h000, 2'd2, 12'h000, -1);
    endtask

    task automatic test_random();
        logic [1:0]  nsel;
        logic [11:0] nrgb;
        for (int k = 0; k < 5; k++) begin
            nsel = 2'($urandom_range(0, 3));
            nrgb = 12'($urandom);
            check_frame("random", cur_sel, cur_rgb, int'($urandom_range(10, 100)),
                        2'($urandom), 12'($urandom), nsel, nrgb, -1);
        end
    endtask

    task automatic test_enable_drop();
        check_frame("drop", cur_sel, cur_rgb, -1, 2'd0, 12'h000, cur_sel, cur_rgb,
                    (VS + VB + 2) * LT + 5);
        check_quiet("after_drop", 30);
        enable = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (frame_start !== 1'b1 || cam_vsync !== 1'b1) begin
            n_err++;
            $display("FAIL reenable: fs=%b vs=%b one clk after enable, required 1 1",
                     frame_start, cam_vsync);
        end
        check_frame("reenable", cur_sel, cur_rgb, -1, 2'd0, 12'h000, 2'd1, 12'h000, -1);
    endtask

    task automatic test_reset_midline();
        int w;
        wait_start("midline", w);
        repeat ((VS + VB) * LT + 10) @(negedge clk);
        n_cmp++;
        if (cam_href !== 1'b1) begin
            n_err++;
            $display("FAIL midline_pre: href=%b before reset, required 1", cam_href);
        end
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        exp_count = 16'h0000;
        check_quiet("midline_reset", 1);
        check_frame("after_reset", cur_sel, cur_rgb, -1, 2'd0, 12'h000, cur_sel, cur_rgb, -1);
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_colour_bars();
        test_solid_latch();
        test_random();
        test_enable_drop();
        test_reset_midline();
        enable = 1'b0;
        repeat (2 * FT) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required bench completion");
        $fatal(1, "watchdog");
    end

endmodule
